seven_segment_capture: RTL
==========================

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

Interface
REQ-001 Parameter WIDTH, default 8: width of the reconstructed word; SHALL be a multiple of 4 and at most 32. DIGITS = WIDTH/4.
REQ-002 Parameter STABLE, default 1: number of consecutive identical synchronized samples required before a digit is accepted; range 1..255.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 seg  input  7  segment lines {a,b,c,d,e,f,g} = seg[6:0], active-low.
REQ-006 anode_activate  input  8  digit enables, active-low; bit i selects digit i (nibble i of word).
REQ-007 word  output  WIDTH  last complete reconstructed word; nibble i = digit i.
REQ-008 word_valid  output  1  one-cycle pulse when word updates.
REQ-009 decode_err  output  1  one-cycle pulse when a stable, selected pattern is not a legal hex glyph.

Function
REQ-010 seg and anode_activate SHALL each pass through a 2-flop synchronizer before any other logic.
REQ-011 A sample is "selected" when exactly one anode_activate bit is low and its index is < DIGITS; zero, multiple, or out-of-range low bits SHALL be treated as blank and ignored.
REQ-012 Legal glyphs (seg[6:0], active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000; any other pattern is illegal.
REQ-013 FSM states: IDLE (blank), SETTLE (selected, counting), HOLD (digit accepted or rejected, waiting for change).
REQ-014 IDLE -> SETTLE when a selected sample appears; stable counter loads 1.
REQ-015 In SETTLE, counter increments each cycle the synchronized {anode, seg} pair equals the previous cycle's; on any change, counter reloads 1 (stays SETTLE) or goes IDLE if now blank.
REQ-016 Edge on which counter reaches STABLE: legal glyph -> nibble written to shadow register, digit mask bit set; illegal glyph -> decode_err pulses next cycle, no write; either way -> HOLD.
REQ-017 HOLD -> SETTLE (counter=1) on any change to a selected sample; HOLD -> IDLE on blank; no further acceptance while unchanged.
REQ-018 Re-acceptance of an already-masked digit SHALL overwrite its shadow nibble.
REQ-019 When an acceptance completes the mask (all DIGITS bits set), on that same edge: word <= shadow including the new nibble, word_valid = 1 for that one cycle, mask cleared.
REQ-020 Latency: input change to word_valid for the last digit = 2 (sync) + STABLE cycles.
REQ-021 word SHALL hold its value between updates; decode_err and word_valid never assert in the same cycle from the same sample.

Reset
REQ-022 While reset is low: word=0, word_valid=0, decode_err=0, shadow=0, mask=0, counter=0, synchronizers=all-ones (blank), FSM=IDLE.
REQ-023 Reset asserted mid-word SHALL discard partial digits; reset release is synchronous to clk.

Verification
REQ-024 WIDTH=8, STABLE=1: anode=11111110 seg=0010010 for 4 cycles, then anode=11111101 seg=0001000 -> word=8'hA2, one-cycle word_valid exactly 3 cycles after second change.
REQ-025 anode=11111110 seg=1111111 held -> decode_err single pulse, mask unchanged, no word_valid.
REQ-026 anode=11111100 or 11111111 or 11111011 (WIDTH=8) with any seg -> no capture, no pulses, FSM IDLE.
REQ-027 STABLE=4: digit 0 glyph 5 held 10 cycles with a 2-cycle seg glitch to 1001111 mid-hold -> glitch ignored, digit 0 = 5, no extra acceptance.
REQ-028 Digit 0 = 7 accepted, reset pulsed low, then only digit 1 = 3 driven -> no word_valid, word=0; then digit 0 = 7 -> word=8'h37.
REQ-029 Continuous scan 11111110/11111101 alternating 8 cycles each with nibbles 4/E -> word_valid pulses once per full scan, word=8'hE4 each time.

Source files
------------

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: rebuilds a hex word by watching a multiplexed, active-low 7-segment display bus.
// Each digit must hold steady for STABLE synchronized samples before it is accepted into the word.
module seven_segment_capture #(
  parameter int WIDTH  = 8,
  parameter int STABLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg,
  input  logic [7:0]       anode_activate,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             decode_err
);
  localparam int DIGITS = WIDTH / 4;
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t            state, state_next;
  logic [6:0]        seg_m, seg_s, seg_p;
  logic [7:0]        an_m, an_s, an_p, low;
  logic [7:0]        cnt, cnt_next;
  logic [2:0]        idx;
  logic [3:0]        nib;
  logic              legal, one_low, sel, changed, fresh, accept, good, bad, done;
  logic [DIGITS-1:0] mask, mask_bit, mask_all;
  logic [WIDTH-1:0]  shadow, shadow_new;

  // Synchronizers idle at all-ones so a reset looks like a blank display.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      seg_m <= '1;
      seg_s <= '1;
      seg_p <= '1;
      an_m  <= '1;
      an_s  <= '1;
      an_p  <= '1;
    end else begin
      seg_m <= seg;
      seg_s <= seg_m;
      seg_p <= seg_s;
      an_m  <= anode_activate;
      an_s  <= an_m;
      an_p  <= an_s;
    end

  always_comb begin
    legal = 1'b1;
    nib   = 4'h0;
    case (seg_s)
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0000100: nib = 4'h9;
      7'b0001000: nib = 4'ha;
      7'b1100000: nib = 4'hb;
      7'b0110001: nib = 4'hc;
      7'b1000010: nib = 4'hd;
      7'b0110000: nib = 4'he;
      7'b0111000: nib = 4'hf;
      default:    legal = 1'b0;
    endcase
  end

  assign low = ~an_s;
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++) if (low[i]) idx = 3'(i);
  end
  assign one_low  = (low != 8'd0) && ((low & (low - 8'd1)) == 8'd0);
  assign sel      = one_low && (32'(idx) < 32'(DIGITS));
  assign changed  = {an_s, seg_s} != {an_p, seg_p};

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_next;

  always_comb
    state_next = !sel                        ? IDLE :
                 accept                      ? HOLD :
                 (state == HOLD && !changed) ? HOLD : SETTLE;

  // HOLD with an unchanged sample is the only case that must not re-accept.
  always_comb begin
    cnt_next = state == IDLE   ? (sel ? 8'd1 : 8'd0) :
               !sel            ? 8'd0 :
               changed         ? 8'd1 :
               state == SETTLE ? cnt + 8'd1 : cnt;
    fresh    = state != HOLD || changed;
    accept   = sel && fresh && cnt_next == 8'(STABLE);
    good     = accept && legal;
    bad      = accept && !legal;
  end

  assign mask_bit   = DIGITS'(1) << idx;
  assign mask_all   = mask | mask_bit;
  assign done       = good && (&mask_all);
  assign shadow_new = (shadow & ~(WIDTH'(4'hf) << {idx, 2'b00})) | (WIDTH'(nib) << {idx, 2'b00});

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt        <= '0;
      mask       <= '0;
      shadow     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      decode_err <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      word_valid <= done;
      decode_err <= bad;
      if (good) begin
        shadow <= shadow_new;
        mask   <= done ? '0 : mask_all;
      end
      if (done) word <= shadow_new;
    end
endmodule
